fx_ram_bridge: RTL

// - Sits between mach's 32-bit RAM port (RAM_A/DI/DO/CEn/WEn/BEn/READYn) and a 16-bit
//   req/ack memory controller (SDRAM arbiter). Each CPU RAM access becomes one or two

---
 rtl/fx_ram_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fx_ram_bridge.sv
// Bridges the CPU's 32-bit RAM port to a 16-bit req/ack memory controller, one or two halfword
// transactions per access. Define FX_RAM_BRIDGE_RDBUF_EN to add a one-word read buffer.
module fx_ram_bridge #(
  parameter int AW = 21
) (
  input  logic          CLK,
  input  logic          RESn,
  input  logic          CE,
  input  logic          BCYSTn,
  input  logic [AW-1:0] RAM_A,
  input  logic [31:0]   RAM_DI,
  output logic [31:0]   RAM_DO,
  input  logic          RAM_CEn,
  input  logic          RAM_WEn,
  input  logic [3:0]    RAM_BEn,
  output logic          RAM_READYn,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-2:0] MEM_A,
  output logic [15:0]   MEM_D,
  output logic [1:0]    MEM_BE,
  input  logic [15:0]   MEM_Q,
  input  logic          MEM_ACK
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LO   = 3'd1;
  localparam logic [2:0] HI   = 3'd2;
  localparam logic [2:0] NOP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state;
  logic [AW-3:0] word_addr;
  logic [31:0]   wdata;
  logic          we;
  logic [3:0]    ben;
  logic          start;
  logic          lo_need_in;
  logic          hi_need_in;
  logic          lo_need;
  logic          hi_need;
  logic          hit;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^RAM_A[1:0];

  assign start      = CE && !BCYSTn && !RAM_CEn && (state == IDLE || state == DONE);
  assign lo_need_in = ~&RAM_BEn[1:0];
  assign hi_need_in = ~&RAM_BEn[3:2];
  assign lo_need    = ~&ben[1:0];
  assign hi_need    = ~&ben[3:2];

`ifdef FX_RAM_BRIDGE_RDBUF_EN
  logic          buf_valid;
  logic [AW-3:0] buf_addr;
  logic [31:0]   buf_data;
  logic          fill;

  // Only a full-word read can populate the buffer, so a valid entry always covers both halves.
  assign fill = (state == HI) && MEM_REQ && MEM_ACK && !we && (ben == 4'h0);
  assign hit  = RAM_WEn && buf_valid && (buf_addr == RAM_A[AW-1:2]) && (lo_need_in || hi_need_in);

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      buf_valid <= 1'b0;
    end else if (start && !RAM_WEn && (buf_addr == RAM_A[AW-1:2])) begin
      buf_valid <= 1'b0;
    end else if (fill) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      buf_addr <= word_addr;
      buf_data <= {MEM_Q, RAM_DO[15:0]};
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state      <= IDLE;
      word_addr  <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      ben        <= 4'hF;
      RAM_DO     <= '0;
      RAM_READYn <= 1'b1;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_A      <= '0;
      MEM_D      <= '0;
      MEM_BE     <= '0;
    end else if (start) begin
      word_addr  <= RAM_A[AW-1:2];
      wdata      <= RAM_DI;
      we         <= !RAM_WEn;
      ben        <= RAM_BEn;
      RAM_READYn <= 1'b1;
      if (hit) begin
`ifdef FX_RAM_BRIDGE_RDBUF_EN
        RAM_DO <= {hi_need_in ? buf_data[31:16] : 16'h0, lo_need_in ? buf_data[15:0] : 16'h0};
`endif
        RAM_READYn <= 1'b0;
        state      <= DONE;
      end else if (lo_need_in) begin
        MEM_REQ <= 1'b1;
        MEM_WE  <= !RAM_WEn;
        MEM_A   <= {RAM_A[AW-1:2], 1'b0};
        MEM_D   <= RAM_DI[15:0];
        MEM_BE  <= ~RAM_BEn[1:0];
        state   <= LO;
      end else if (hi_need_in) begin
        MEM_REQ <= 1'b1;
        MEM_WE  <= !RAM_WEn;
        MEM_A   <= {RAM_A[AW-1:2], 1'b1};
        MEM_D   <= RAM_DI[31:16];
        MEM_BE  <= ~RAM_BEn[3:2];
        state   <= HI;
      end else begin
        state <= NOP;
      end
    end else begin
      case (state)
        LO: begin
          if (MEM_REQ && MEM_ACK) begin
            if (!we) RAM_DO[15:0] <= MEM_Q;
            // HI follows in the very next cycle: REQ stays up and only the payload changes.
            if (hi_need) begin
              MEM_A  <= {word_addr, 1'b1};
              MEM_D  <= wdata[31:16];
              MEM_BE <= ~ben[3:2];
              state  <= HI;
            end else begin
              if (!we) RAM_DO[31:16] <= 16'h0;
              MEM_REQ    <= 1'b0;
              RAM_READYn <= 1'b0;
              state      <= DONE;
            end
          end
        end
        HI: begin
          if (MEM_REQ && MEM_ACK) begin
            if (!we) begin
              RAM_DO[31:16] <= MEM_Q;
              if (!lo_need) RAM_DO[15:0] <= 16'h0;
            end
            MEM_REQ    <= 1'b0;
            RAM_READYn <= 1'b0;
            state      <= DONE;
          end
        end
        NOP: begin
          if (!we) RAM_DO <= '0;
          RAM_READYn <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
          if (RAM_CEn) begin
            RAM_READYn <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
